// File: rtl/capture_timer.sv
// Input-capture peripheral: measures prescaled ticks between selected cap_in edges on the 6502 register bus.
// Latency: edge acted on two clocks after synchronisation; reads combinational; no backpressure (writes always accepted).
module capture_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] addr,
    input  logic       we,
    input  logic [7:0] dbw,
    output logic [7:0] dbr,
    input  logic       cap_in,
    output logic       irq
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t      state, state_nx;
    logic [15:0] cap, cap_nx;
    logic [15:0] cnt, cnt_nx;
    logic [7:0]  pc, pc_nx;
    logic [7:0]  presc;
    logic        en, edge_sel, ie;
    logic        captured, captured_nx;
    logic        missed, missed_nx;
    logic        sat, sat_nx;
    logic        s0, s1, prev;

    logic        ev;
    logic        wr_ctrl;
    logic        tick_end;
    logic [15:0] cnt_inc;

    assign ev       = edge_sel ? (~s1 & prev) : (s1 & ~prev);
    assign wr_ctrl  = we & (addr == 2'd2);
    assign tick_end = (pc == presc);
    assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s0   <= cap_in;
            s1   <= s0;
            prev <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= 8'd0;
            en       <= 1'b0;
            edge_sel <= 1'b0;
            ie       <= 1'b0;
        end else if (we) begin
            if (addr == 2'd3)
                presc <= dbw;
            if (addr == 2'd2) begin
                en       <= dbw[0];
                edge_sel <= dbw[1];
                ie       <= dbw[2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cap      <= 16'd0;
            cnt      <= 16'd0;
            pc       <= 8'd0;
            captured <= 1'b0;
            missed   <= 1'b0;
            sat      <= 1'b0;
        end else begin
            state    <= state_nx;
            cap      <= cap_nx;
            cnt      <= cnt_nx;
            pc       <= pc_nx;
            captured <= captured_nx;
            missed   <= missed_nx;
            sat      <= sat_nx;
        end
    end

    // A control write takes priority over any edge arriving in the same cycle.
    always_comb begin
        state_nx    = state;
        cap_nx      = cap;
        cnt_nx      = cnt;
        pc_nx       = pc;
        captured_nx = captured;
        missed_nx   = missed;
        sat_nx      = sat;
        if (wr_ctrl) begin
            captured_nx = 1'b0;
            missed_nx   = 1'b0;
            sat_nx      = 1'b0;
            cnt_nx      = 16'd0;
            pc_nx       = 8'd0;
            state_nx    = dbw[0] ? ARM : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nx = 16'd0;
                    pc_nx  = 8'd0;
                end
                ARM: begin
                    if (ev) begin
                        state_nx = MEASURE;
                        cnt_nx   = 16'd0;
                        pc_nx    = 8'd0;
                    end
                end
                MEASURE: begin
                    if (ev) begin
                        // The tick completing on the edge cycle is still counted.
                        cap_nx      = tick_end ? cnt_inc : cnt;
                        cnt_nx      = 16'd0;
                        pc_nx       = 8'd0;
                        missed_nx   = captured;
                        captured_nx = 1'b1;
                    end else if (tick_end) begin
                        pc_nx  = 8'd0;
                        cnt_nx = cnt_inc;
                        if (cnt_inc == 16'hFFFF)
                            sat_nx = 1'b1;
                    end else begin
                        pc_nx = pc + 8'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        dbr = 8'd0;
        case (addr)
            2'd0: dbr = cap[7:0];
            2'd1: dbr = cap[15:8];
            2'd2: dbr = {captured, missed, sat, 2'b00, ie, edge_sel, en};
            2'd3: dbr = presc;
            default: dbr = 8'd0;
        endcase
    end

    assign irq = captured & ie;

endmodule
